// File: rtl/banked_main_mem_pkg.sv
// banked_main_mem_pkg: address-field constants, defaults and helpers
// shared by the banked main memory and the cache controller.
package banked_main_mem_pkg;

  localparam int NUM_BANKS    = 4;
  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 16;
  localparam int BANK_LSB     = 1;
  localparam int BANK_MSB     = 2;
  localparam int WORD_IDX_LSB = 3;

  localparam int DEF_WORDS_PER_BANK = 8192;
  localparam int DEF_BUSY_CYCLES    = 4;
  localparam int DEF_READ_LAT       = 2;

  typedef logic [BANK_MSB-BANK_LSB:0] bank_t;
  typedef logic [DATA_W-1:0]          word_t;
  typedef logic [ADDR_W-1:0]          addr_t;

  function automatic bank_t bank_of(
    input addr_t a
  );
    return a[BANK_MSB:BANK_LSB];
  endfunction

  function automatic logic is_legal(
    input logic  r,
    input logic  w,
    input addr_t a
  );
    return (r ^ w) & ~a[0];
  endfunction

  function automatic logic is_err(
    input logic  r,
    input logic  w,
    input addr_t a
  );
    return (r & w) | ((r | w) & a[0]);
  endfunction

endpackage

// File: rtl/banked_main_mem_mem_bank.sv
// mem_bank: one interleaved bank; storage, occupancy counter, read sample.
// Ports: clk, rst, i_sel (legal request to this bank), i_wr, i_idx,
//        i_wdata, o_busy (bank occupied), o_rdata (word sampled on read accept).
module mem_bank
  import banked_main_mem_pkg::*;
#(
  parameter int WORDS       = DEF_WORDS_PER_BANK,
  parameter int BUSY_CYCLES = DEF_BUSY_CYCLES,
  parameter int IDX_W       = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sel,
  input  logic             i_wr,
  input  logic [IDX_W-1:0] i_idx,
  input  word_t            i_wdata,
  output logic             o_busy,
  output word_t            o_rdata
);

  localparam int CNT_W = $clog2(BUSY_CYCLES) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_LOAD = cnt_t'(BUSY_CYCLES - 1);

  word_t r_mem [WORDS];
  word_t r_rdata;
  cnt_t  r_cnt;
  logic  w_acc;

  assign o_busy  = (r_cnt != '0);
  assign w_acc   = i_sel & ~o_busy;
  assign o_rdata = r_rdata;

  // Occupancy: the accept edge loads BUSY_CYCLES-1 so the bank is
  // free again exactly BUSY_CYCLES cycles after the accept cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_acc) begin
      r_cnt <= CNT_LOAD;
    end else if (o_busy) begin
      r_cnt <= r_cnt - cnt_t'(1);
    end
  end

  // Storage has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      if (i_wr) begin
        r_mem[i_idx] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_idx];
      end
    end
  end

endmodule

// File: rtl/banked_main_mem.sv
// banked_main_mem: four-bank interleaved main memory behind the cache.
// Ports: clk, rst (sync, active-high), addr (byte address), data_in, wr, rd,
//        data_out (read return, 0 when idle), stall, busy[3:0], err.
module banked_main_mem
  import banked_main_mem_pkg::*;
#(
  parameter int WORDS_PER_BANK = DEF_WORDS_PER_BANK,
  parameter int BUSY_CYCLES    = DEF_BUSY_CYCLES,
  parameter int READ_LAT       = DEF_READ_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 wr,
  input  logic                 rd,
  output logic [DATA_W-1:0]    data_out,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  localparam int IDX_W = $clog2(WORDS_PER_BANK);

  bank_t                w_bank;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_legal;
  logic                 w_err;
  logic                 w_rd_acc;
  logic [NUM_BANKS-1:0] w_sel;
  logic [NUM_BANKS-1:0] w_busy;
  word_t                w_rdata [NUM_BANKS];

  // Return pipeline: stage 0 remembers which bank was read, stage 1
  // picks up that bank's sampled word, later stages only delay it.
  logic [READ_LAT-1:0]  r_vld;
  bank_t                r_bank;
  word_t                r_dat [READ_LAT-1:1];

  always_comb begin
    w_bank   = bank_of(addr);
    w_idx    = addr[WORD_IDX_LSB +: IDX_W];
    w_legal  = is_legal(rd, wr, addr);
    w_err    = is_err(rd, wr, addr);
    w_sel    = '0;
    w_sel[w_bank] = w_legal & ~rst;
    w_rd_acc = w_legal & rd & ~rst & ~w_busy[w_bank];
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    mem_bank #(
      .WORDS       (WORDS_PER_BANK),
      .BUSY_CYCLES (BUSY_CYCLES),
      .IDX_W       (IDX_W)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .i_sel   (w_sel[g]),
      .i_wr    (wr),
      .i_idx   (w_idx),
      .i_wdata (data_in),
      .o_busy  (w_busy[g]),
      .o_rdata (w_rdata[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      r_vld <= {r_vld[READ_LAT-2:0], w_rd_acc};
    end
  end

  // The source bank stays busy for at least two cycles, so its sampled
  // word is stable when stage 1 captures it.
  always_ff @(posedge clk) begin
    r_bank   <= w_bank;
    r_dat[1] <= w_rdata[r_bank];
    for (int i = 2; i < READ_LAT; i++) begin
      r_dat[i] <= r_dat[i-1];
    end
  end

  assign data_out = r_vld[READ_LAT-1] ? r_dat[READ_LAT-1] : '0;
  assign stall    = w_legal & w_busy[w_bank];
  assign busy     = w_busy;
  assign err      = w_err;

endmodule

// File: tb/tb_banked_main_mem.sv
// tb_banked_main_mem: scoreboard bench for the banked main memory.
// Expected reads are queued with their due cycle and checked on data_out.
module tb_banked_main_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  banked_main_mem dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .wr       (wr),
    .rd       (rd),
    .data_out (data_out),
    .stall    (stall),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    bit          rd;
    bit          wr;
    bit          hold;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;

  exp_t        sb [$];
  logic [15:0] mm [int];
  int          free_at [4];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      logic [15:0] want;
      want = 16'h0;
      if (sb.size() != 0 && sb[0].due == cyc) begin
        want = sb[0].data;
        void'(sb.pop_front());
      end
      checks++;
      if (data_out !== want) begin
        failures++;
        $display("FAIL data_out cyc=%0d got=%h want=%h", cyc, data_out, want);
      end
    end
  end

  function automatic req_t f_wr(input logic [15:0] a, input logic [15:0] d,
                                input bit h);
    req_t r;
    r = '{rd: 1'b0, wr: 1'b1, hold: h, addr: a, data: d};
    return r;
  endfunction

  function automatic req_t f_rd(input logic [15:0] a, input bit h);
    req_t r;
    r = '{rd: 1'b1, wr: 1'b0, hold: h, addr: a, data: 16'h0};
    return r;
  endfunction

  function automatic req_t f_idle();
    req_t r;
    r = '{rd: 1'b0, wr: 1'b0, hold: 1'b0, addr: 16'h0, data: 16'h0};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of stimulus, updates the reference model and
  // returns what stall/err/busy must look like in this cycle.
  task automatic drive(input bit r, input bit w, input logic [15:0] a,
                       input logic [15:0] d, output logic es,
                       output logic ee, output logic [3:0] eb);
    bit lg;
    bit acc;
    int b;
    rd = r;
    wr = w;
    addr = a;
    data_in = d;
    b = int'(a[2:1]);
    for (int i = 0; i < 4; i++) eb[i] = (cyc < free_at[i]);
    ee = (r & w) | ((r | w) & a[0]);
    lg = (r ^ w) & ~a[0];
    es = lg & eb[b];
    acc = lg & ~eb[b] & ~rst;
    if (acc) begin
      free_at[b] = cyc + 4;
      if (w) mm[int'(a[15:1])] = d;
      else sb.push_back('{due: cyc + 2, data: mm[int'(a[15:1])]});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd = 1'b0;
    wr = 1'b0;
    addr = 16'h0;
    data_in = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) free_at[i] = 0;
    sb.delete();
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 4'b0000 || stall !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset busy/stall/err got=%b/%b/%b want=0000/0/0",
               busy, stall, err);
    end
    tick();
  endtask

  task automatic test_write_read();
    req_t t [$];
    logic es, ee;
    logic [3:0] eb;
    t = '{f_wr(16'h0010, 16'hBEEF, 1'b1), f_idle(), f_idle(), f_idle(),
          f_idle(), f_rd(16'h0010, 1'b1), f_idle(), f_idle(), f_idle()};
    foreach (t[i]) begin
      drive(t[i].rd, t[i].wr, t[i].addr, t[i].data, es, ee, eb);
      checks++;
      if (stall !== es || err !== ee || busy !== eb) begin
        failures++;
        $display("FAIL write_read step=%0d stall/err/busy got=%b/%b/%b want=%b/%b/%b",
                 i, stall, err, busy, es, ee, eb);
      end
      if (i >= 1 && i <= 3) begin
        checks++;
        if (busy !== 4'b0001) begin
          failures++;
          $display("FAIL write_busy step=%0d got=%b want=0001", i, busy);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    req_t t [$];
    logic es, ee;
    logic [3:0] eb;
    t = '{f_wr(16'h0040, 16'h1111, 1'b0), f_wr(16'h0042, 16'h2222, 1'b0),
          f_wr(16'h0044, 16'h3333, 1'b0), f_wr(16'h0046, 16'h4444, 1'b0),
          f_rd(16'h0040, 1'b0), f_rd(16'h0042, 1'b0),
          f_rd(16'h0044, 1'b0), f_rd(16'h0046, 1'b0),
          f_idle(), f_idle(), f_idle(), f_idle()};
    foreach (t[i]) begin
      drive(t[i].rd, t[i].wr, t[i].addr, t[i].data, es, ee, eb);
      checks++;
      if (stall !== 1'b0 || stall !== es || err !== ee || busy !== eb) begin
        failures++;
        $display("FAIL back_to_back step=%0d stall/err/busy got=%b/%b/%b want=%b/%b/%b",
                 i, stall, err, busy, es, ee, eb);
      end
      tick();
    end
  endtask

  task automatic test_bank_conflict();
    req_t t [$];
    logic es, ee;
    logic [3:0] eb;
    int nst;
    t = '{f_wr(16'h0020, 16'h5A5A, 1'b1), f_idle(), f_idle(), f_idle(),
          f_wr(16'h0028, 16'hC3C3, 1'b1), f_idle(), f_idle(), f_idle(),
          f_rd(16'h0020, 1'b1)};
    foreach (t[i]) begin
      drive(t[i].rd, t[i].wr, t[i].addr, t[i].data, es, ee, eb);
      checks++;
      if (stall !== es || err !== ee || busy !== eb) begin
        failures++;
        $display("FAIL conflict_prep step=%0d stall/err/busy got=%b/%b/%b want=%b/%b/%b",
                 i, stall, err, busy, es, ee, eb);
      end
      tick();
    end
    nst = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 16'h0028, 16'h0, es, ee, eb);
      checks++;
      if (stall !== es || err !== ee || busy !== eb) begin
        failures++;
        $display("FAIL conflict try=%0d stall/err/busy got=%b/%b/%b want=%b/%b/%b",
                 k, stall, err, busy, es, ee, eb);
      end
      tick();
      if (!es) break;
      nst++;
    end
    checks++;
    if (nst != 3) begin
      failures++;
      $display("FAIL conflict_stall_cycles got=%0d want=3", nst);
    end
    repeat (4) begin
      drive(1'b0, 1'b0, 16'h0, 16'h0, es, ee, eb);
      tick();
    end
  endtask

  task automatic test_err();
    req_t t [$];
    logic es, ee;
    logic [3:0] eb;
    t = '{'{rd: 1'b1, wr: 1'b1, hold: 1'b0, addr: 16'h0040, data: 16'h9999},
          f_rd(16'h0021, 1'b0), f_wr(16'h0023, 16'h7777, 1'b0), f_idle(),
          f_rd(16'h0040, 1'b0), f_rd(16'h0041, 1'b0),
          '{rd: 1'b1, wr: 1'b1, hold: 1'b0, addr: 16'h0040, data: 16'h8888},
          f_idle(), f_idle(), f_idle()};
    foreach (t[i]) begin
      drive(t[i].rd, t[i].wr, t[i].addr, t[i].data, es, ee, eb);
      checks++;
      if (stall !== es || err !== ee || busy !== eb) begin
        failures++;
        $display("FAIL err step=%0d stall/err/busy got=%b/%b/%b want=%b/%b/%b",
                 i, stall, err, busy, es, ee, eb);
      end
      tick();
    end
    // Bank 0 still holds 0x1111: the erroring writes changed nothing.
    drive(1'b1, 1'b0, 16'h0040, 16'h0, es, ee, eb);
    tick();
    repeat (3) begin
      drive(1'b0, 1'b0, 16'h0, 16'h0, es, ee, eb);
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic es, ee;
    logic [3:0] eb;
    drive(1'b1, 1'b0, 16'h0010, 16'h0, es, ee, eb);
    tick();
    rst = 1'b1;
    while (sb.size() != 0 && sb[$].due > cyc) void'(sb.pop_back());
    drive(1'b0, 1'b0, 16'h0, 16'h0, es, ee, eb);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) free_at[i] = 0;
    drive(1'b0, 1'b0, 16'h0, 16'h0, es, ee, eb);
    checks++;
    if (busy !== 4'b0000 || stall !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid busy/stall/err got=%b/%b/%b want=0000/0/0",
               busy, stall, err);
    end
    tick();
    drive(1'b1, 1'b0, 16'h0010, 16'h0, es, ee, eb);
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_reread stall got=%b want=0", stall);
    end
    tick();
    repeat (4) begin
      drive(1'b0, 1'b0, 16'h0, 16'h0, es, ee, eb);
      tick();
    end
  endtask

  task automatic test_stall_write();
    req_t t [$];
    logic es, ee;
    logic [3:0] eb;
    int tries;
    t = '{f_wr(16'h0100, 16'h1234, 1'b1), f_idle(), f_idle(), f_idle(),
          f_rd(16'h0010, 1'b1), f_wr(16'h0100, 16'hAAAA, 1'b0),
          f_idle(), f_idle(), f_rd(16'h0100, 1'b1), f_idle(), f_idle(),
          f_idle(), f_wr(16'h0100, 16'hAAAA, 1'b1), f_idle(), f_idle(),
          f_idle(), f_rd(16'h0100, 1'b1), f_idle(), f_idle(), f_idle()};
    foreach (t[i]) begin
      tries = 0;
      do begin
        drive(t[i].rd, t[i].wr, t[i].addr, t[i].data, es, ee, eb);
        checks++;
        if (stall !== es || err !== ee || busy !== eb) begin
          failures++;
          $display("FAIL stall_write step=%0d stall/err/busy got=%b/%b/%b want=%b/%b/%b",
                   i, stall, err, busy, es, ee, eb);
        end
        tick();
        tries++;
      end while (t[i].hold && es && tries < 8);
      if (t[i].hold && es) begin
        failures++;
        $display("FAIL stall_write_timeout step=%0d got=stalled want=accepted", i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_bank_conflict();
    test_err();
    test_reset_mid();
    test_stall_write();
    repeat (4) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending want=0", sb.size());
    end
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/banked_main_mem.md
Name: banked_main_mem

Overview:
- Four-bank interleaved main-memory model. Sits directly downstream of the direct-mapped cache controller.
- Consumes the controller's memory requests (address, write data, wr, rd). Returns read data, stall, per-bank busy and error.
- Banks are independent and overlap, so the controller can issue one word per cycle to successive banks during line fills and evictions.

Parameters:
- WORDS_PER_BANK, 8192, 16-bit words stored per bank; 4 banks x 8192 words = 64 KB byte space.
- BUSY_CYCLES, 4, cycles a bank is occupied per accepted access, counting the accept cycle.
- READ_LAT, 2, cycles from read accept to data on data_out.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- addr  in  16  byte address; bank = addr[2:1], word index within bank = addr[15:3]
- data_in  in  16  write data
- wr  in  1  write request
- rd  in  1  read request
- data_out  out  16  read return data; 0 when no return in this cycle
- stall  out  1  request present but target bank busy; request not accepted
- busy  out  4  per-bank occupancy, bit b = bank b
- err  out  1  illegal request in this cycle

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high.
- Reset values: data_out=0, stall=0, busy=4'b0000, err=0.
  - Reset clears all bank busy counters and the read-return pipeline.
  - Storage contents are retained across reset.
- Request legality (combinational):
  - err=1 if (rd & wr), or if (rd|wr) & addr[0].
  - An erroring request is dropped with no state change; stall=0 in that cycle.
- Stall (combinational): stall = (rd^wr) & ~addr[0] & busy[addr[2:1]].
  - A stalled request is dropped. The requester must hold and re-present it.
- Accept: a legal request whose target bank is not busy is accepted at the rising edge ending cycle t.
  - Write: storage[bank][index] <= data_in at that edge.
  - Read: storage is sampled at that edge.
  - Accepted read data appears on data_out for exactly one cycle, t+READ_LAT. data_out is 0 in all other cycles.
- Busy: after acceptance in cycle t, busy[b]=1 for cycles t+1 .. t+BUSY_CYCLES-1 (3 cycles at default).
  - Bank b may be accepted again at cycle t+BUSY_CYCLES.
  - Implemented as a per-bank down-counter loaded with BUSY_CYCLES-1; busy = (count != 0).
- Overlap: at most one accept per cycle (single port), so read returns never collide on data_out.
  - Reads to banks 0,1,2,3 in consecutive cycles t..t+3 return in t+2..t+5.
- Ordering: a write followed by a read to the same bank is separated by at least BUSY_CYCLES by construction. The read returns the written value.
- Reset mid-operation: any in-flight read return is cancelled, so data_out=0 in the cycle after rst. All banks are free in the first cycle after rst deasserts.
- Idle: rd=wr=0 gives no state change and stall=err=0.

Decomposition:
- Shared package constants:
  - NUM_BANKS=4
  - BANK_LSB=1, BANK_MSB=2
  - WORD_IDX_LSB=3
  - default BUSY_CYCLES and READ_LAT
- The cache controller uses the same bank-field constants to walk banks 0..3.
- Sub-module mem_bank, instantiated 4 times. Each contains:
  - storage array
  - busy counter
  - accept and read-data output for its bank
- The top level holds:
  - decode and err/stall logic
  - READ_LAT-deep return pipeline (valid + data)
  - data_out mux

Test Plan:
- Reset, then write 0xBEEF to 0x0010 (bank 0) → busy=4'b0001 for 3 cycles. Then read 0x0010 at cycle t → data_out=0xBEEF at t+2 only, 0 elsewhere.
- Write 0x1111, 0x2222, 0x3333, 0x4444 to 0x0040, 0x0042, 0x0044, 0x0046 on consecutive cycles → no stall. Reads of the same four addresses on consecutive cycles → data_out shows 0x1111..0x4444 on 4 consecutive cycles.
- Read 0x0020, then read 0x0028 (same bank 0) on the next cycle → stall=1 for cycles t+1..t+3. Request accepted at t+4; data returned at t+6.
- rd=wr=1, and separately rd=1 with addr=0x0021 → err=1, stall=0, busy unchanged, no data_out return.
- Read 0x0010 accepted at t, rst=1 at t+1 → data_out=0 at t+2, busy=0. A subsequent read of 0x0010 returns 0xBEEF (contents retained).
- Write 0xAAAA to 0x0100 while busy[0]=1 from a prior access → stall=1 and no write. Re-present after the bank frees → accepted. Readback is 0xAAAA.
